// File: rtl/tap_ctrl_param_if.sv
// Core-side parallel bundle of the TAP controller: decoded instruction and user data register.
// Latency: ir_out/user_dr_out change one rising edge after Update-IR/Update-DR; user_update is state-decoded.
// Backpressure: none; user_dr_in is sampled unconditionally in Capture-DR.
interface tap_ctrl_param_if #(
    parameter int IR_WIDTH = 4,
    parameter int DR_WIDTH = 8
);
    logic [IR_WIDTH-1:0] ir_out;
    logic [DR_WIDTH-1:0] user_dr_in;
    logic [DR_WIDTH-1:0] user_dr_out;
    logic                user_update;

    // TAP side drives the instruction and update register, core side supplies capture data
    modport master (
        output ir_out,
        output user_dr_out,
        output user_update,
        input  user_dr_in
    );

    modport slave (
        input  ir_out,
        input  user_dr_out,
        input  user_update,
        output user_dr_in
    );
endinterface

// File: rtl/tap_ctrl_param.sv
// IEEE 1149.1 TAP controller with parametrised IR, 32-bit IDCODE, bypass and one user DR.
// Latency: state and registers advance on each GCLK_Pad rising edge; TDO_Pad is combinational from state.
// Backpressure: none; the pad side dictates every cycle and the core side only observes/supplies data.
module tap_ctrl_param #(
    parameter int          IR_WIDTH     = 4,
    parameter int          DR_WIDTH     = 8,
    parameter logic [31:0] IDCODE_VAL   = 32'h1000_0001,
    parameter int          INSTR_IDCODE = 1,
    parameter int          INSTR_USER   = 2
) (
    input  logic                   GCLK_Pad,
    input  logic                   TRST_Pad,
    input  logic                   TMS_Pad,
    input  logic                   TDI_Pad,
    output logic                   TDO_Pad,
    output logic [3:0]             state_obs_Pad,
    tap_ctrl_param_if.master       core
);

    // Encoding is the bring-up observation code, so it must not be re-encoded by synthesis
    typedef enum logic [3:0] {
        EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
        SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
        EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
        RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(INSTR_IDCODE);
    localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(INSTR_USER);

    tap_state_e          state_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] ir_sr_q;
    logic [31:0]         id_sr_q;
    logic [DR_WIDTH-1:0] user_sr_q;
    logic [DR_WIDTH-1:0] user_dr_q;
    logic                byp_q;
    logic                sel_idcode;
    logic                sel_user;

    // IDCODE wins if both opcodes were configured equal; anything unrecognised routes to bypass
    assign sel_idcode = (ir_q == OP_IDCODE);
    assign sel_user   = (ir_q == OP_USER) && !sel_idcode;

    // TAP state machine: 1149.1 transition graph driven by TMS
    always_ff @(posedge GCLK_Pad or negedge TRST_Pad) begin
        if (!TRST_Pad) begin
            state_q <= TLR;
        end else begin
            case (state_q)
                TLR:    state_q <= TMS_Pad ? TLR    : RTI;
                RTI:    state_q <= TMS_Pad ? SEL_DR : RTI;
                SEL_DR: state_q <= TMS_Pad ? SEL_IR : CAP_DR;
                CAP_DR: state_q <= TMS_Pad ? EX1_DR : SH_DR;
                SH_DR:  state_q <= TMS_Pad ? EX1_DR : SH_DR;
                EX1_DR: state_q <= TMS_Pad ? UPD_DR : PAU_DR;
                PAU_DR: state_q <= TMS_Pad ? EX2_DR : PAU_DR;
                EX2_DR: state_q <= TMS_Pad ? UPD_DR : SH_DR;
                UPD_DR: state_q <= TMS_Pad ? SEL_DR : RTI;
                SEL_IR: state_q <= TMS_Pad ? TLR    : CAP_IR;
                CAP_IR: state_q <= TMS_Pad ? EX1_IR : SH_IR;
                SH_IR:  state_q <= TMS_Pad ? EX1_IR : SH_IR;
                EX1_IR: state_q <= TMS_Pad ? UPD_IR : PAU_IR;
                PAU_IR: state_q <= TMS_Pad ? EX2_IR : PAU_IR;
                EX2_IR: state_q <= TMS_Pad ? UPD_IR : SH_IR;
                UPD_IR: state_q <= TMS_Pad ? SEL_DR : RTI;
            endcase
        end
    end

    // Data path: the action of each state takes effect on the edge that leaves it
    always_ff @(posedge GCLK_Pad or negedge TRST_Pad) begin
        if (!TRST_Pad) begin
            ir_q      <= OP_IDCODE;
            ir_sr_q   <= '0;
            id_sr_q   <= '0;
            user_sr_q <= '0;
            user_dr_q <= '0;
            byp_q     <= 1'b0;
        end else begin
            case (state_q)
                TLR:    ir_q    <= OP_IDCODE;
                CAP_IR: ir_sr_q <= IR_WIDTH'(1);
                SH_IR:  ir_sr_q <= IR_WIDTH'({TDI_Pad, ir_sr_q} >> 1);
                UPD_IR: ir_q    <= ir_sr_q;
                CAP_DR: begin
                    id_sr_q   <= IDCODE_VAL;
                    user_sr_q <= core.user_dr_in;
                    byp_q     <= 1'b0;
                end
                SH_DR: begin
                    if (sel_idcode)    id_sr_q   <= {TDI_Pad, id_sr_q[31:1]};
                    else if (sel_user) user_sr_q <= DR_WIDTH'({TDI_Pad, user_sr_q} >> 1);
                    else               byp_q     <= TDI_Pad;
                end
                UPD_DR: if (sel_user) user_dr_q <= user_sr_q;
                default: ;
            endcase
        end
    end

    // TDO shows the LSB of whichever register is in a shift state, so the first captured bit is visible before any shift
    always_comb begin
        TDO_Pad = 1'b0;
        if (state_q == SH_IR) begin
            TDO_Pad = ir_sr_q[0];
        end else if (state_q == SH_DR) begin
            if (sel_idcode)    TDO_Pad = id_sr_q[0];
            else if (sel_user) TDO_Pad = user_sr_q[0];
            else               TDO_Pad = byp_q;
        end
    end

    assign state_obs_Pad    = state_q;
    assign core.ir_out      = ir_q;
    assign core.user_dr_out = user_dr_q;
    assign core.user_update = (state_q == UPD_DR) && sel_user;

endmodule

// File: tb/tb_tap_ctrl_param.sv
// Bench for tap_ctrl_param: directed TMS/TDI vectors against a queue-based TAP model.
// Latency: model advances on each rising edge; outputs compared on every falling edge.
// Backpressure: none; stimulus is fully pad-driven.
module tb_tap_ctrl_param;
    localparam int          IRW = 4;
    localparam int          DRW = 8;
    localparam logic [31:0] IDV = 32'h1000_0001;

    logic       GCLK_Pad = 1'b0;
    logic       TRST_Pad = 1'b0;
    logic       TMS_Pad  = 1'b1;
    logic       TDI_Pad  = 1'b0;
    logic       TDO_Pad;
    logic [3:0] state_obs_Pad;

    tap_ctrl_param_if #(.IR_WIDTH(IRW), .DR_WIDTH(DRW)) u_if ();

    tap_ctrl_param #(
        .IR_WIDTH(IRW), .DR_WIDTH(DRW), .IDCODE_VAL(IDV),
        .INSTR_IDCODE(1), .INSTR_USER(2)
    ) dut (
        .GCLK_Pad(GCLK_Pad), .TRST_Pad(TRST_Pad), .TMS_Pad(TMS_Pad), .TDI_Pad(TDI_Pad),
        .TDO_Pad(TDO_Pad), .state_obs_Pad(state_obs_Pad), .core(u_if)
    );

    always #5 GCLK_Pad = ~GCLK_Pad;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Next state per encoding, read straight off the 1149.1 transition list
    int n0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int n1 [16] = '{5, 5, 1, 0, 15,  7, 1, 4, 13, 13,  9,  8,  7,  7,  9, 15};

    // Model: registers kept as bit queues, front element = LSB = TDO bit
    int          m_state = 15;
    logic [3:0]  m_ir    = 4'd1;
    logic [7:0]  m_udr   = 8'd0;
    logic [31:0] idv_v   = IDV;
    bit          irq[$];
    bit          idq[$];
    bit          usq[$];
    bit          byq[$];
    bit          cmp_en  = 1'b0;
    int          upd_cnt = 0;

    function automatic int msel();
        if (m_ir == 4'd1) return 1;
        if (m_ir == 4'd2) return 2;
        return 0;
    endfunction

    function automatic void m_reset();
        m_state = 15;
        m_ir    = 4'd1;
        m_udr   = 8'd0;
        irq.delete(); idq.delete(); usq.delete(); byq.delete();
        for (int i = 0; i < IRW; i++) irq.push_back(1'b0);
        for (int i = 0; i < 32; i++)  idq.push_back(1'b0);
        for (int i = 0; i < DRW; i++) usq.push_back(1'b0);
        byq.push_back(1'b0);
    endfunction

    always @(posedge GCLK_Pad or negedge TRST_Pad) begin
        if (!TRST_Pad) begin
            m_reset();
        end else begin
            case (m_state)
                15: m_ir = 4'd1;
                14: begin
                    irq.delete();
                    irq.push_back(1'b1);
                    for (int i = 1; i < IRW; i++) irq.push_back(1'b0);
                end
                10: begin void'(irq.pop_front()); irq.push_back(TDI_Pad); end
                13: for (int i = 0; i < IRW; i++) m_ir[i] = irq[i];
                6: begin
                    idq.delete(); usq.delete(); byq.delete();
                    for (int i = 0; i < 32; i++)  idq.push_back(idv_v[i]);
                    for (int i = 0; i < DRW; i++) usq.push_back(u_if.user_dr_in[i]);
                    byq.push_back(1'b0);
                end
                2: case (msel())
                    1:       begin void'(idq.pop_front()); idq.push_back(TDI_Pad); end
                    2:       begin void'(usq.pop_front()); usq.push_back(TDI_Pad); end
                    default: begin void'(byq.pop_front()); byq.push_back(TDI_Pad); end
                endcase
                5: if (msel() == 2) for (int i = 0; i < DRW; i++) m_udr[i] = usq[i];
                default: ;
            endcase
            m_state = TMS_Pad ? n1[m_state] : n0[m_state];
        end
    end

    // Compare every output against the model on every falling edge
    always @(negedge GCLK_Pad) begin
        if (cmp_en) begin
            logic exp_tdo;
            exp_tdo = 1'b0;
            if (m_state == 10) exp_tdo = irq[0];
            else if (m_state == 2) begin
                case (msel())
                    1:       exp_tdo = idq[0];
                    2:       exp_tdo = usq[0];
                    default: exp_tdo = byq[0];
                endcase
            end
            chk("cyc_state", 32'(state_obs_Pad), 32'(m_state));
            chk("cyc_tdo", 32'(TDO_Pad), 32'(exp_tdo));
            chk("cyc_ir_out", 32'(u_if.ir_out), 32'(m_ir));
            chk("cyc_user_dr_out", 32'(u_if.user_dr_out), 32'(m_udr));
            chk("cyc_user_update", 32'(u_if.user_update), 32'((m_state == 5) && (msel() == 2)));
            if (u_if.user_update === 1'b1) upd_cnt++;
        end
    end

    task automatic step(input bit tms, input bit tdi);
        TMS_Pad = tms;
        TDI_Pad = tdi;
        @(posedge GCLK_Pad);
        #1;
    endtask

    // From RTI: load an instruction, returning the captured IR bits seen on TDO
    task automatic ir_scan(input logic [3:0] v, output logic [3:0] t);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < IRW; i++) begin
            t[i] = TDO_Pad;
            step(i == IRW - 1, v[i]);
        end
        step(1, 0); step(0, 0);
    endtask

    // From RTI: shift n bits through the selected DR, ending back in RTI
    task automatic dr_scan(input int n, input logic [31:0] v, output logic [31:0] t);
        t = '0;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < n; i++) begin
            t[i] = TDO_Pad;
            step(i == n - 1, v[i]);
        end
        step(1, 0);
        chk("in_upd_dr", 32'(state_obs_Pad), 32'h5);
        step(0, 0);
    endtask

    bit    wtms [44] = '{1,0,0,1,0,0,0,1,0,0,1,0,1,1,0,1,0,1,0,1,1,1,1,0,0,0,1,0,0,1,0,1,1,0,1,1,0,1,0,1,1,1,1,1};
    int    wexp [44] = '{15,12,12,7,6,2,2,1,3,3,0,2,1,5,12,7,6,1,3,0,5,7,4,14,10,10,9,11,11,8,10,9,13,12,7,4,14,9,11,8,13,7,4,15};
    string pre  [16] = '{"", "0", "01", "010", "0100", "0101", "01010", "010101", "01011",
                         "011", "0110", "01100", "01101", "011010", "0110101", "011011"};
    int    ptgt [16] = '{15, 12, 7, 6, 2, 1, 3, 0, 5, 4, 14, 10, 9, 11, 8, 13};
    int    sh_tlr [5] = '{1, 5, 7, 4, 15};

    initial begin
        logic [3:0]  t4;
        logic [31:0] t32;
        u_if.user_dr_in = 8'h00;

        // Reset held two cycles
        @(posedge GCLK_Pad); #1;
        cmp_en = 1'b1;
        @(posedge GCLK_Pad); #1;
        chk("rst_state", 32'(state_obs_Pad), 32'hF);
        chk("rst_ir_out", 32'(u_if.ir_out), 32'h1);
        chk("rst_user_dr_out", 32'(u_if.user_dr_out), 32'h0);
        chk("rst_tdo", 32'(TDO_Pad), 32'h0);
        TRST_Pad = 1'b1;
        step(0, 0);
        chk("rti_after_rst", 32'(state_obs_Pad), 32'hC);

        // Walk covering all 32 arcs
        step(1, 0); step(1, 0); step(1, 0);
        for (int i = 0; i < 44; i++) begin
            step(wtms[i], 0);
            chk("arc_walk", 32'(state_obs_Pad), 32'(wexp[i]));
        end

        // ShDR exit sequence under constant TMS=1
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int j = 0; j < 5; j++) begin
            step(1, 0);
            chk("shdr_to_tlr", 32'(state_obs_Pad), 32'(sh_tlr[j]));
        end

        // Every state reaches TLR after five TMS=1 edges
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < pre[i].len(); k++) begin
                byte c;
                c = pre[i][k];
                step(c == "1", 0);
            end
            chk("reach_state", 32'(state_obs_Pad), 32'(ptgt[i]));
            for (int j = 0; j < 5; j++) step(1, 0);
            chk("five_ones_tlr", 32'(state_obs_Pad), 32'hF);
        end

        // IDCODE read straight after TLR
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        t32 = '0;
        for (int i = 0; i < 32; i++) begin
            t32[i] = TDO_Pad;
            step(i == 31, 0);
        end
        chk("idcode_stream", t32, 32'h1000_0001);
        step(1, 0); step(0, 0);

        // USER instruction and a DR scan
        ir_scan(4'h2, t4);
        chk("ir_capture_tdo", 32'(t4), 32'h1);
        chk("ir_user", 32'(u_if.ir_out), 32'h2);
        u_if.user_dr_in = 8'h3C;
        upd_cnt = 0;
        dr_scan(DRW, 32'hA5, t32);
        chk("user_capture_tdo", t32, 32'h3C);
        chk("user_dr_out_a5", 32'(u_if.user_dr_out), 32'hA5);
        chk("user_update_cnt", 32'(upd_cnt), 32'd1);

        // BYPASS gives a one-cycle delay and leaves the user register alone
        ir_scan(4'hF, t4);
        chk("ir_capture_tdo2", 32'(t4), 32'h1);
        chk("ir_bypass", 32'(u_if.ir_out), 32'hF);
        upd_cnt = 0;
        dr_scan(4, 32'b1101, t32);
        chk("bypass_tdo", t32, 32'b1010);
        chk("bypass_udr_hold", 32'(u_if.user_dr_out), 32'hA5);
        chk("bypass_no_update", 32'(upd_cnt), 32'd0);

        // Reset in the middle of a USER DR shift
        ir_scan(4'h2, t4);
        u_if.user_dr_in = 8'h77;
        upd_cnt = 0;
        step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(0, 1); step(0, 1);
        TRST_Pad = 1'b0;
        #1;
        chk("abort_state", 32'(state_obs_Pad), 32'hF);
        chk("abort_udr", 32'(u_if.user_dr_out), 32'h0);
        chk("abort_ir", 32'(u_if.ir_out), 32'h1);
        chk("abort_tdo", 32'(TDO_Pad), 32'h0);
        @(posedge GCLK_Pad); #1;
        TRST_Pad = 1'b1;
        chk("abort_no_update", 32'(upd_cnt), 32'd0);

        // IR capture after the abort
        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        t4 = '0;
        for (int i = 0; i < IRW; i++) begin
            t4[i] = TDO_Pad;
            step(i == IRW - 1, 0);
        end
        chk("post_abort_ir_tdo", 32'(t4), 32'h1);
        for (int j = 0; j < 5; j++) step(1, 0);
        chk("final_tlr", 32'(state_obs_Pad), 32'hF);

        @(negedge GCLK_Pad);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tap_ctrl_param.md
Name: tap_ctrl_param

Overview:
- Parametrised successor to the TAP routing block: full IEEE 1149.1 16-state TAP controller plus instruction register, bypass, IDCODE and one user data register, with serial TDI/TDO.
- Keeps the 4-bit state observation output used for bring-up, and adds configurable IR and user-DR widths.
- Sits between the chip pads and on-chip configuration/test logic. It exports the decoded instruction and the updated user-DR value.

Parameters:
- IR_WIDTH, 4, instruction register width (>=2)
- DR_WIDTH, 8, user data register width (>=1)
- IDCODE_VAL, 32'h1000_0001, IDCODE register content; LSB must be 1
- INSTR_IDCODE, 1, opcode selecting IDCODE
- INSTR_USER, 2, opcode selecting user DR; all-ones = BYPASS; any other opcode selects BYPASS

Ports:
- GCLK_Pad  input  1  clock; all state changes on the rising edge
- TRST_Pad  input  1  asynchronous, active-low reset
- TMS_Pad  input  1  test mode select, sampled on the rising edge
- TDI_Pad  input  1  serial data in, sampled on the rising edge
- TDO_Pad  output  1  serial data out
- state_obs_Pad  output  4  current TAP state encoding
- ir_out  output  IR_WIDTH  active instruction, i.e. the update stage of the IR
- user_dr_in  input  DR_WIDTH  parallel value loaded in Capture-DR when USER is active
- user_dr_out  output  DR_WIDTH  user DR update register
- user_update  output  1  one-cycle pulse, high while in Update-DR with USER active

Behaviour:
- State encoding, also driven on state_obs_Pad:
  - TLR=F, RTI=C
  - SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D
- Transitions follow 1149.1 exactly:
  - TLR: TMS=1 stay, TMS=0 -> RTI
  - RTI: TMS=1 -> SelDR, TMS=0 stay
  - SelDR: TMS=1 -> SelIR, TMS=0 -> CapDR
  - SelIR: TMS=1 -> TLR, TMS=0 -> CapIR
  - Cap*: TMS=1 -> Ex1, TMS=0 -> Sh
  - Sh*: TMS=1 -> Ex1, TMS=0 stay
  - Ex1*: TMS=1 -> Upd, TMS=0 -> Pau
  - Pau*: TMS=1 -> Ex2, TMS=0 stay
  - Ex2*: TMS=1 -> Upd, TMS=0 -> Sh
  - Upd*: TMS=1 -> SelDR, TMS=0 -> RTI
- Five consecutive TMS=1 edges reach TLR from any state.
- Asynchronous reset (TRST_Pad=0):
  - state=TLR (state_obs_Pad=F), ir_out=INSTR_IDCODE, IR shift reg=0, user_dr_out=0, bypass=0.
  - TDO_Pad=0, user_update=0.
  - Reset mid-scan aborts the scan; no update occurs.
- Synchronous TLR: every cycle spent in TLR forces ir_out=INSTR_IDCODE. user_dr_out keeps its value.
- IR path:
  - CapIR: IR shift reg <= {0..0,01} (LSB=1, bit1=0).
  - ShIR: shift right, TDI_Pad enters the MSB.
  - UpdIR: ir_out <= IR shift reg.
- DR selection by ir_out: IDCODE -> 32-bit IDCODE reg; USER -> DR_WIDTH user shift reg; otherwise -> 1-bit bypass.
- DR capture (CapDR): IDCODE reg <= IDCODE_VAL; user shift reg <= user_dr_in; bypass <= 0.
- DR shift (ShDR): the selected register shifts right with TDI_Pad entering the MSB. Unselected registers hold.
- DR update (UpdDR):
  - USER selected: user_dr_out <= user shift reg; user_update=1 for that cycle only.
  - Otherwise: no register change.
- TDO_Pad: combinational LSB of the IR shift reg in ShIR, or of the selected DR in ShDR; 0 in all other states. The first captured bit is therefore visible on entering Sh*, before the first shift edge.
- Pause/Exit states hold all shift registers.
- Shift counts longer than the register width simply continue shifting: the TDI bits shifted in appear on TDO after W cycles.
- ir_out changes only in UpdIR or TLR, never mid-scan.

Test Plan:
- TRST_Pad low for 2 cycles -> state_obs_Pad=F, ir_out=1, user_dr_out=0, TDO_Pad=0. Then TMS=0 -> state_obs_Pad=C.
- From ShDR, TMS=1 for 5 edges -> state_obs_Pad sequence 1,5,7,4,F. From each of the 16 states, five TMS=1 edges -> F. All 32 state/TMS arcs are checked against the table.
- After reset, TMS 1,0,0 -> ShDR; 32 shifts with TDI=0 -> TDO stream is IDCODE_VAL LSB-first (0x10000001).
- IR scan loading 4'h2 (TMS 1,1,0,0, shift 0,1,0,0 with TMS=1 on the last bit, then 1,0). Then with user_dr_in=8'h3C, a DR scan shifting 8'hA5:
  - TDO returns 0x3C LSB-first.
  - At UpdDR, user_dr_out=8'hA5 and user_update is high for exactly 1 cycle.
- IR scan loads 4'hF (BYPASS); DR scan of pattern 1,0,1,1 -> TDO = 0 (captured bypass), 1,0,1: a one-cycle delay. user_dr_out is unchanged.
- TRST_Pad asserted mid-ShDR during a USER scan -> immediate state F, user_dr_out=0, ir_out=1, no user_update pulse. CapIR followed by 4 shifts returns TDO 1,0,0,0.
